// File: rtl/multicycle_control_v2.sv
// Control FSM for the multicycle RV32I datapath: memory ready/wait handshake,
// full branch set, optional JALR/LUI decode, illegal-opcode trap and a
// retired-instruction counter. Outputs are decoded from the registered state;
// only the fetch/branch PC enables and the handshake-qualified strobes also
// look at the current inputs.
module multicycle_control_v2 #(
    parameter int MEM_WAIT_EN = 1,
    parameter int ALUCTRL_W   = 4,
    parameter int EXT_EN      = 1,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           MemSize,
    output logic                 MemUnsigned,
    output logic                 Illegal,
    output logic                 InstrDone,
    output logic [CNT_W-1:0]     InstRet
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE,
        ALU_WB, BRANCH, JAL, JMP, JALR, LUI, AUIPC, ILLEGAL
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                           ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8,
                           ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

    state_t     state, state_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_rdy;
    logic       taken;
    logic       done;
    logic [3:0] alu_op;
    logic       unused_instr;

    assign opcode  = Instr[6:0];
    assign funct3  = Instr[14:12];
    // Without wait states every access completes in the cycle it is issued.
    assign mem_rdy = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // funct3 -> ALU operation; alt selects SUB / SRA.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Branch condition from the SUB flags {N,Z,C,V}; C means no borrow.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = ALUFlags[2];
            3'b001:  taken = !ALUFlags[2];
            3'b100:  taken = ALUFlags[3] ^ ALUFlags[0];
            3'b101:  taken = !(ALUFlags[3] ^ ALUFlags[0]);
            3'b110:  taken = !ALUFlags[1];
            3'b111:  taken = ALUFlags[1];
            default: taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // Retire counter and sticky trap flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstRet <= '0;
            Illegal <= 1'b0;
        end else begin
            if (done)               InstRet <= InstRet + CNT_W'(1);
            if (state_n == ILLEGAL) Illegal <= 1'b1;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n     = state;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 3'b000;
        RegWrite    = 1'b0;
        alu_op      = ALU_ADD;
        MemSize     = 2'b10;
        MemUnsigned = 1'b0;
        done        = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b10;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
                if (mem_rdy) state_n = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (opcode)
                    7'b0110011: state_n = EXEC_R;
                    7'b0010011: state_n = EXEC_I;
                    7'b0000011,
                    7'b0100011: state_n = MEM_ADR;
                    7'b1100011: state_n = BRANCH;
                    7'b1101111: state_n = JAL;
                    7'b1100111: state_n = (EXT_EN != 0) ? JALR : ILLEGAL;
                    7'b0110111: state_n = (EXT_EN != 0) ? LUI : ILLEGAL;
                    7'b0010111: state_n = AUIPC;
                    default:    state_n = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                ALUSrcA = 2'b10;
                alu_op  = alu_decode(funct3, Instr[30]);
                state_n = ALU_WB;
            end
            EXEC_I: begin
                // rs1 is the first operand; bit 30 only distinguishes SRAI.
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = alu_decode(funct3, Instr[30] && (funct3 == 3'b101));
                state_n = ALU_WB;
            end
            MEM_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = Instr[5] ? 3'b001 : 3'b000;
                state_n = Instr[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                AdrSrc      = 1'b1;
                MemRead     = 1'b1;
                MemSize     = Instr[13:12];
                MemUnsigned = Instr[14];
                if (mem_rdy) state_n = MEM_WB;
            end
            MEM_WB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                done      = 1'b1;
                state_n   = FETCH;
            end
            MEM_WRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                MemSize  = Instr[13:12];
                if (mem_rdy) begin
                    done    = 1'b1;
                    state_n = FETCH;
                end
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                done     = 1'b1;
                state_n  = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_SUB;
                if (funct3[2:1] == 2'b01) begin
                    state_n = ILLEGAL;
                end else begin
                    PCWrite = taken;
                    done    = 1'b1;
                    state_n = FETCH;
                end
            end
            JAL, JALR: begin
                // Link value OldPC+4 is written while the target is formed next.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                state_n   = JMP;
            end
            JMP: begin
                // Opcode bit 3 separates JAL (PC-relative) from JALR (rs1-based).
                ALUSrcA   = Instr[3] ? 2'b01 : 2'b10;
                ALUSrcB   = 2'b01;
                ImmSrc    = Instr[3] ? 3'b100 : 3'b000;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                done      = 1'b1;
                state_n   = FETCH;
            end
            LUI: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b011;
                alu_op  = ALU_PASSB;
                state_n = ALU_WB;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b011;
                state_n = ALU_WB;
            end
            ILLEGAL: state_n = ILLEGAL;
            default: state_n = FETCH;
        endcase
    end

    assign ALUControl = ALUCTRL_W'(alu_op);
    assign InstrDone  = done;

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Randomized bench for multicycle_control_v2: instructions are classified from
// their opcode and timed from the FETCH-to-FETCH latency table; memory waits
// are scheduled by the bench. dut0 uses default parameters, dut1 has wait
// states and JALR/LUI disabled and a 3-bit retire counter.
module tb_multicycle_control_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0, reset1, sel;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;

    logic       PCWrite0, AdrSrc0, MemRead0, MemWrite0, IRWrite0, RegWrite0;
    logic       MemUnsigned0, Illegal0, InstrDone0;
    logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, MemSize0;
    logic [2:0] ImmSrc0;
    logic [3:0] ALUControl0;
    logic [31:0] InstRet0;

    logic       PCWrite1, AdrSrc1, MemRead1, MemWrite1, IRWrite1, RegWrite1;
    logic       MemUnsigned1, Illegal1, InstrDone1;
    logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, MemSize1;
    logic [2:0] ImmSrc1;
    logic [3:0] ALUControl1;
    logic [2:0] InstRet1;

    multicycle_control_v2 dut0 (
        .clk(clk), .reset(reset0), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .MemRead(MemRead0), .MemWrite(MemWrite0),
        .IRWrite(IRWrite0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
        .ImmSrc(ImmSrc0), .RegWrite(RegWrite0), .ALUControl(ALUControl0), .MemSize(MemSize0),
        .MemUnsigned(MemUnsigned0), .Illegal(Illegal0), .InstrDone(InstrDone0), .InstRet(InstRet0)
    );

    multicycle_control_v2 #(.MEM_WAIT_EN(0), .ALUCTRL_W(4), .EXT_EN(0), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset1), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .MemRead(MemRead1), .MemWrite(MemWrite1),
        .IRWrite(IRWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
        .ImmSrc(ImmSrc1), .RegWrite(RegWrite1), .ALUControl(ALUControl1), .MemSize(MemSize1),
        .MemUnsigned(MemUnsigned1), .Illegal(Illegal1), .InstrDone(InstrDone1), .InstRet(InstRet1)
    );

    // Observed bundles of the selected DUT.
    logic [6:0]  o_ctl;   // {MemRead, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone, Illegal}
    logic [13:0] o_mux;   // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
    logic [2:0]  o_mem;   // {MemSize, MemUnsigned}
    logic [31:0] o_ret;

    assign o_ctl = sel ? {MemRead1, MemWrite1, IRWrite1, PCWrite1, RegWrite1, InstrDone1, Illegal1}
                       : {MemRead0, MemWrite0, IRWrite0, PCWrite0, RegWrite0, InstrDone0, Illegal0};
    assign o_mux = sel ? {AdrSrc1, ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1, ALUControl1}
                       : {AdrSrc0, ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0, ALUControl0};
    assign o_mem = sel ? {MemSize1, MemUnsigned1} : {MemSize0, MemUnsigned0};
    assign o_ret = sel ? {29'd0, InstRet1} : InstRet0;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    logic [3:0] alu_tab [8] = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    logic [2:0] br_f3 [6]   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input bit alt);
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd8;
        return alu_tab[f3];
    endfunction

    function automatic bit is_legal_op(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    // Holds the selected DUT in reset; it is released at the start of the next instruction.
    task automatic do_reset();
        #1;
        if (sel) reset1 = 1'b1; else reset0 = 1'b1;
        MemReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", o_ctl, {1'b1, 1'b0, sel, sel, 3'b000});
        chk("rst_ret", o_ret, 32'd0);
        @(posedge clk);
        model_cnt = 0;
    endtask

    // Random instruction of a given class; branch flags come from real operands.
    task automatic gen(input int kind, output logic [31:0] ins, output logic [3:0] flags,
                       output bit taken);
        logic [31:0] a, b, d;
        logic [6:0]  op;
        logic [2:0]  f3;
        ins   = $urandom;
        f3    = ins[14:12];
        flags = 4'($urandom);
        taken = 1'b0;
        case (kind)
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4, 10: begin
                op = 7'h63;
                a  = $urandom;
                case ($urandom_range(0, 2))
                    0:       b = a;
                    1:       b = a ^ 32'h8000_0000;
                    default: b = $urandom;
                endcase
                d     = a - b;
                flags = {d[31], d == 32'd0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
                if (kind == 10) begin
                    f3 = 3'(2 + $urandom_range(0, 1));
                end else begin
                    f3 = br_f3[$urandom_range(0, 5)];
                    case (f3)
                        3'd0:    taken = (a == b);
                        3'd1:    taken = (a != b);
                        3'd4:    taken = ($signed(a) < $signed(b));
                        3'd5:    taken = ($signed(a) >= $signed(b));
                        3'd6:    taken = (a < b);
                        default: taken = (a >= b);
                    endcase
                end
            end
            5: op = 7'h6F;
            6: op = 7'h67;
            7: op = 7'h37;
            8: op = 7'h17;
            default: begin
                op = 7'($urandom);
                while (is_legal_op(op)) op = 7'($urandom);
            end
        endcase
        ins[6:0]   = op;
        ins[14:12] = f3;
    endtask

    // Runs one instruction from FETCH, checking every cycle against the timeline
    // predicted from its class, the wait counts and the latency table.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] flags, input bit taken,
                             input int wf_in, input int wd_in, input int hold);
        logic [6:0]  op, ectl;
        logic [2:0]  f3;
        logic [13:0] emux, efin;
        logic [31:0] mask;
        bit waits, ext, r, i, ld, st, br, brx, jal, jalr, lui, aui, legal;
        int wf, wd, len, last, ill_at, ncyc, ds, de;
        op    = ins[6:0];
        f3    = ins[14:12];
        waits = !sel;
        ext   = !sel;
        mask  = sel ? 32'd7 : 32'hFFFF_FFFF;
        wf    = waits ? wf_in : 0;
        wd    = waits ? wd_in : 0;
        r     = (op == 7'h33);
        i     = (op == 7'h13);
        ld    = (op == 7'h03);
        st    = (op == 7'h23);
        br    = (op == 7'h63);
        jal   = (op == 7'h6F);
        jalr  = ext && (op == 7'h67);
        lui   = ext && (op == 7'h37);
        aui   = (op == 7'h17);
        legal = r || i || ld || st || br || jal || jalr || lui || aui;
        brx   = br && (f3 == 3'd2 || f3 == 3'd3);
        len   = br ? 3 : (ld ? 5 : 4);
        ds    = wf + 3;
        de    = ds + wd;
        if (!legal)   ill_at = wf + 2;
        else if (brx) ill_at = wf + 3;
        else          ill_at = -1;
        last  = (ill_at >= 0) ? -1 : wf + len - 1 + ((ld || st) ? wd : 0);
        ncyc  = (ill_at >= 0) ? ill_at + hold : last + 1;

        if (r)                emux = {1'b0, 2'b00, 2'b10, 2'b00, 3'b000, alu_code(f3, ins[30])};
        else if (i)           emux = {1'b0, 2'b00, 2'b10, 2'b01, 3'b000, alu_code(f3, ins[30] && f3 == 3'd5)};
        else if (ld)          emux = {1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0};
        else if (st)          emux = {1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0};
        else if (br)          emux = {1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1};
        else if (jal || jalr) emux = {1'b0, 2'b10, 2'b01, 2'b10, 3'b000, 4'd0};
        else if (lui)         emux = {1'b0, 2'b00, 2'b00, 2'b01, 3'b011, 4'd10};
        else if (aui)         emux = {1'b0, 2'b00, 2'b01, 2'b01, 3'b011, 4'd0};
        else                  emux = 14'd0;

        if (ld)        efin = {1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0};
        else if (jal)  efin = {1'b0, 2'b10, 2'b01, 2'b01, 3'b100, 4'd0};
        else if (jalr) efin = {1'b0, 2'b10, 2'b10, 2'b01, 3'b000, 4'd0};
        else           efin = 14'd0;

        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (c == 0) begin
                Instr    = ins;
                ALUFlags = flags;
                if (sel) reset1 = 1'b0; else reset0 = 1'b0;
            end
            if (waits && c <= wf)                              MemReady = (c == wf);
            else if (waits && (ld || st) && c >= ds && c <= de) MemReady = (c == de);
            else                                               MemReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            ectl = {(c <= wf) || (ld && c >= ds && c <= de),
                    st && c >= ds && c <= de,
                    c == wf,
                    (c == wf) || (c == last && ((br && taken) || jal || jalr)),
                    (c == last && (r || i || lui || aui || ld)) || ((jal || jalr) && c == wf + 2),
                    c == last,
                    (ill_at >= 0) && (c >= ill_at)};
            chk("ctl", {25'd0, o_ctl}, {25'd0, ectl});
            if (c == 0)      chk("instret", o_ret, model_cnt & mask);
            if (c == wf + 1) chk("decode", {18'd0, o_mux}, {18'd0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b010, 4'd0});
            if (c == wf + 2) chk("exec", {18'd0, o_mux}, {18'd0, emux});
            if ((ld || st) && c >= ds && c <= de)
                chk("mem", {28'd0, o_mux[13], o_mem}, {28'd0, 1'b1, f3[1:0], ld & f3[2]});
            if (c == last && last != wf + 2 && !st)
                chk("final", {18'd0, o_mux}, {18'd0, efin});
            @(posedge clk);
        end
        if (ill_at >= 0) do_reset();
        else             model_cnt++;
    endtask

    // Reset lands while a store waits for MemReady; the write request must drop.
    task automatic mid_write_reset();
        #1;
        reset0   = 1'b0;
        Instr    = 32'h0020A223;
        MemReady = 1'b1;
        @(posedge clk);                 // FETCH
        #1 MemReady = 1'b0;
        @(posedge clk);                 // DECODE
        @(posedge clk);                 // MEM_ADR
        @(negedge clk);
        chk("wr_req", {31'd0, o_ctl[5]}, 32'd1);
        reset0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wr_drop", {30'd0, o_ctl[6:5]}, 32'd2);
        chk("wr_ret", o_ret, 32'd0);
        @(posedge clk);
        model_cnt = 0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  flags;
        bit          taken;
        reset0 = 1'b1; reset1 = 1'b1; sel = 1'b0;
        Instr = 32'd0; ALUFlags = 4'd0; MemReady = 1'b0;
        @(posedge clk);
        do_reset();

        // Directed cases on the default configuration.
        run_instr(32'h002081B3, 4'b0000, 1'b0, 0, 0, 3);    // add
        run_instr(32'h0000A183, 4'b0000, 1'b0, 3, 2, 3);    // lw with waits
        run_instr(32'h0020C463, 4'b1000, 1'b1, 1, 0, 3);    // blt taken
        run_instr(32'h0020C463, 4'b1001, 1'b0, 0, 0, 3);    // blt not taken
        run_instr(32'h123450B7, 4'b0000, 1'b0, 0, 0, 3);    // lui
        run_instr(32'h0000007F, 4'b0000, 1'b0, 0, 0, 20);   // illegal opcode

        repeat (200) begin
            gen($urandom_range(0, 10), ins, flags, taken);
            run_instr(ins, flags, taken, $urandom_range(0, 3), $urandom_range(0, 3), 3);
        end
        mid_write_reset();

        // Second configuration: no waits, no JALR/LUI, 3-bit counter.
        #1 reset0 = 1'b1;
        sel = 1'b1;
        @(posedge clk);
        do_reset();
        run_instr(32'h123450B7, 4'b0000, 1'b0, 0, 0, 3);    // lui traps here
        repeat (10) run_instr(32'h002081B3, 4'b0000, 1'b0, 0, 0, 3);
        repeat (80) begin
            gen($urandom_range(0, 10), ins, flags, taken);
            run_instr(ins, flags, taken, 0, 0, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_v2.md
Name: multicycle_control_v2

Overview:
- Parametrised next-generation control FSM for the multicycle RV32I datapath.
- Adds the following over the previous control unit:
  - a memory ready/wait-state handshake;
  - the full branch set, plus JALR and LUI;
  - illegal-opcode trapping;
  - a retired-instruction counter.
- Sits between the instruction register/ALU flags and every datapath mux/enable.
- Outputs are Moore-decoded from the registered state, except PCWrite in BRANCH and the handshake-qualified strobes.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour MemReady; 0 = treat MemReady as constant 1.
- ALUCTRL_W, 4: width of ALUControl; minimum 4, upper bits zero.
- EXT_EN, 1: 1 = decode JALR/LUI; 0 = treat those opcodes as illegal.
- CNT_W, 32: width of the retire counter.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high.
- Instr, input, 32: instruction register contents.
- ALUFlags, input, 4: {N,Z,C,V} from the ALU; C = no-borrow on SUB.
- MemReady, input, 1: memory completes the access this cycle.
- PCWrite, output, 1: PC enable.
- AdrSrc, output, 1: 0 = PC, 1 = ALUOut.
- MemRead, output, 1: read request.
- MemWrite, output, 1: write request.
- IRWrite, output, 1: IR/OldPC enable.
- ResultSrc, output, 2: 00 = ALUOut, 01 = MemData, 10 = ALU result.
- ALUSrcA, output, 2: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB, output, 2: 00 = rs2, 01 = imm, 10 = const 4.
- ImmSrc, output, 3: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- RegWrite, output, 1: register-file write.
- ALUControl, output, ALUCTRL_W: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 SLTU, 10 PASSB.
- MemSize, output, 2: Instr[13:12] during memory states, else 2'b10.
- MemUnsigned, output, 1: Instr[14] during MEM_READ, else 0.
- Illegal, output, 1: sticky trap flag.
- InstrDone, output, 1: one-cycle retire pulse.
- InstRet, output, CNT_W: retired-instruction count.

Behaviour:
- Reset:
  - All logic is clocked on clk and reset is synchronous.
  - Reset sets state = FETCH, InstRet = 0, Illegal = 0.
  - Reset has priority over every other event, including mid-access: an outstanding memory request is dropped (MemRead/MemWrite low the next cycle).
- Default outputs: every output not listed for a state below is 0. The exceptions are MemSize = 2'b10 and ALUControl = ADD.
- FETCH:
  - AdrSrc = 0, MemRead = 1, ALUSrcA = 00, ALUSrcB = 10, ADD.
  - IRWrite and PCWrite = MemReady.
  - Go to DECODE on MemReady; otherwise stay.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, ImmSrc = B, ADD (precomputes the branch target).
  - Dispatch on Instr[6:0]:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 / 0100011 → MEM_ADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR (only when EXT_EN = 1)
    - 0110111 → LUI (only when EXT_EN = 1)
    - 0010111 → AUIPC
    - anything else → ILLEGAL
- EXEC_R:
  - ALUSrcA = 10, ALUSrcB = 00.
  - ALUControl is decoded from funct3 and Instr[30]: SUB and SRA when Instr[30] = 1.
  - Next state: ALU_WB.
- EXEC_I:
  - ALUSrcB = 01, ImmSrc = I.
  - Same funct3 decode as EXEC_R; Instr[30] is honoured only for funct3 = 101.
  - Next state: ALU_WB.
- MEM_ADR:
  - ALUSrcA = 10, ALUSrcB = 01, ImmSrc = I for loads and S for stores, ADD.
  - Next state: MEM_READ for loads, MEM_WRITE for stores.
- MEM_READ:
  - AdrSrc = 1, MemRead = 1.
  - Go to MEM_WB on MemReady.
- MEM_WB:
  - ResultSrc = 01, RegWrite = 1.
  - Next state: FETCH.
- MEM_WRITE:
  - AdrSrc = 1, MemWrite = 1, held until MemReady.
  - Go to FETCH on MemReady.
- ALU_WB: ResultSrc = 00, RegWrite = 1, next state FETCH.
- BRANCH:
  - ALUSrcA = 10, ALUSrcB = 00, SUB, ResultSrc = 00.
  - PCWrite = taken, where:
    - BEQ: Z
    - BNE: !Z
    - BLT: N^V
    - BGE: !(N^V)
    - BLTU: !C
    - BGEU: C
  - funct3 010/011 → ILLEGAL and no PCWrite.
  - Otherwise next state FETCH.
- JAL:
  - ALUSrcA = 01, ALUSrcB = 10, ADD.
  - ResultSrc = 00 writes the DECODE result? No: ResultSrc = 10 writes OldPC+4 with RegWrite = 1.
  - Next state: JMP.
- JMP:
  - ALUSrcA = 01 for JAL or 10 for JALR; ALUSrcB = 01; ImmSrc = J or I.
  - ResultSrc = 10, PCWrite = 1.
  - JALR clears bit 0 in the datapath.
  - Next state: FETCH.
- JALR: same as JAL, then JMP.
- LUI: ALUSrcB = 01, ImmSrc = U, PASSB, next state ALU_WB.
- AUIPC: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = U, ADD, next state ALU_WB.
- ILLEGAL:
  - Illegal is set and held.
  - All enables are 0; the FSM remains here until reset.
- Retire (InstrDone):
  - Pulses in the final cycle of each instruction:
    - ALU_WB
    - MEM_WB
    - MEM_WRITE with MemReady
    - BRANCH (legal funct3)
    - JMP
  - InstRet increments on the same edge and wraps modulo 2^CNT_W.
- Handshake rules:
  - Request outputs stay stable while MemReady = 0.
  - With MEM_WAIT_EN = 0, every memory state lasts exactly one cycle.
- Latency with MemReady = 1, FETCH to FETCH:
  - R/I/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL/JALR: 4 cycles.

Test Plan:
1. Reset, then add x3,x1,x2 (0x002081B3) with MemReady = 1 → states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite = 1 in cycle 4; InstRet = 1.
2. lw 0x0000A183 with MemReady low for 3 cycles in FETCH and 2 cycles in MEM_READ → MemRead held; IRWrite exactly one pulse; RegWrite after 10 cycles total; MemSize = 10.
3. blt with flags N = 1, V = 0 → PCWrite = 1 in BRANCH. Repeat with N = V = 1 → PCWrite = 0. InstrDone pulses in both cases.
4. Opcode 0x7F → Illegal = 1 after DECODE and held for 20 cycles. Then reset → FETCH, Illegal = 0, InstRet = 0.
5. EXT_EN = 0 with LUI 0x123450B7 → ILLEGAL. EXT_EN = 1 → ALUControl = PASSB, ImmSrc = 011, RegWrite.
6. CNT_W = 3: retire 9 instructions → InstRet = 1 (wraps). Assert reset in the middle of MEM_WRITE with MemReady = 0 → MemWrite = 0 on the next cycle.
